// File: rtl/aim65_tty_rx.sv
// aim65_tty_rx: 8N1 serial receiver for the AIM-65 TTY line, with receive FIFO.
// Optional macro TTY_RX_MAJORITY_EN enables 2-of-3 majority sampling at every sample point.
// Ports: cpu_clk, reset_n (async, active-low), serial_in (async line), baud_div;
//        rx_data/rx_valid/rx_ready (FWFT pop), fifo_count; sticky framing_err/overrun_err with err_clr; busy.
module aim65_tty_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          cpu_clk,
  input  logic                          reset_n,
  input  logic                          serial_in,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_err,
  output logic                          overrun_err,
  input  logic                          err_clr,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, edge_q;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 ferr_q, ovr_q;
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           mem [FIFO_DEPTH];

  logic s_in, cnt_zero, smp, sval, push, ferr_set;
  logic pop, full, wr, ovr_set, in_frame;

  assign s_in     = sync2_q;
  assign cnt_zero = (cnt_q == '0);
  assign in_frame = (state_q == START) || (state_q == DATA) ||
                    (state_q == STOP);

`ifdef TTY_RX_MAJORITY_EN
  // Samples at cnt=1 and cnt=0 are held; the vote closes one cycle later.
  logic m1_q, m0_q, pend_q;

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      m1_q   <= 1'b1;
      m0_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      if (cnt_q == DIV_WIDTH'(1)) m1_q <= s_in;
      if (cnt_zero)               m0_q <= s_in;
      pend_q <= in_frame && cnt_zero;
    end
  end

  assign smp  = pend_q;
  assign sval = (m1_q & m0_q) | (m1_q & s_in) | (m0_q & s_in);
`else
  assign smp  = cnt_zero;
  assign sval = s_in;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    // Free-running bit timer: reload a full period on every expiry.
    if (in_frame)
      cnt_d = cnt_zero ? div_q - 1'b1 : cnt_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if (edge_q && !s_in) begin
          state_d = START;
          div_d   = baud_div;
          cnt_d   = (baud_div >> 1) - 1'b1;
        end
      end
      START: begin
        if (smp) begin
          state_d = sval ? IDLE : DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (smp) begin
          shift_d[bit_q] = sval;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (smp) begin
          if (sval) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        if (s_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop is resolved first, so a full FIFO still takes a byte when popped.
  assign pop     = rx_valid && rx_ready;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + 1'b1;
    else if (!wr && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_set ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
      ovr_q   <= ovr_set  ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (wr) mem[wptr_q] <= shift_q;
  end

  assign rx_valid    = (count_q != '0);
  assign rx_data     = rx_valid ? mem[rptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign framing_err = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_aim65_tty_rx.sv
// tb_aim65_tty_rx: directed self-checking bench for aim65_tty_rx.
// Frames are driven bit-by-bit on serial_in; outputs are sampled at negedge.
module tb_aim65_tty_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_in;
  logic [15:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  fifo_count;
  logic        framing_err;
  logic        overrun_err;
  logic        err_clr;
  logic        busy;

  int errors = 0;
  int checks = 0;

`ifdef TTY_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  aim65_tty_rx #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .cpu_clk     (clk),
    .reset_n     (rst_n),
    .serial_in   (serial_in),
    .baud_div    (baud_div),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_count  (fifo_count),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Caller is at a negedge; returns at a negedge with the line idle.
  task automatic send_frame(input logic [7:0] b, input int div,
                            input logic stop);
    serial_in = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (div) @(negedge clk);
    end
    serial_in = stop;
    repeat (div) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic pop1();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || fifo_count !== 5'd0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_fifo got v=%b c=%0d d=%h exp 0 0 00",
               rx_valid, fifo_count, rx_data);
    end
    checks++;
    if (framing_err !== 1'b0 || overrun_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got f=%b o=%b b=%b exp 0 0 0",
               framing_err, overrun_err, busy);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    checks++;
    if (fifo_count !== 5'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty got c=%0d v=%b exp 0 0",
               fifo_count, rx_valid);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h55, 104, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || fifo_count !== 5'd1 || rx_data !== 8'h55) begin
      errors++;
      $display("FAIL basic_first got v=%b c=%0d d=%h exp 1 1 55",
               rx_valid, fifo_count, rx_data);
    end
    send_frame(8'hA3, 104, 1'b1);
    checks++;
    if (fifo_count !== 5'd2 || rx_data !== 8'h55) begin
      errors++;
      $display("FAIL basic_second got c=%0d d=%h exp 2 55",
               fifo_count, rx_data);
    end
    pop1();
    checks++;
    if (fifo_count !== 5'd1 || rx_data !== 8'hA3) begin
      errors++;
      $display("FAIL basic_pop1 got c=%0d d=%h exp 1 a3",
               fifo_count, rx_data);
    end
    pop1();
    checks++;
    if (fifo_count !== 5'd0 || rx_valid !== 1'b0 ||
        framing_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop2 got c=%0d v=%b f=%b o=%b exp 0 0 0 0",
               fifo_count, rx_valid, framing_err, overrun_err);
    end
  endtask

  task automatic test_false_start();
    logic seen_busy;
    seen_busy = 1'b0;
    serial_in = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    serial_in = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b1) begin
      errors++;
      $display("FAIL false_start_busy got %b exp 1", seen_busy);
    end
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || framing_err !== 1'b0) begin
      errors++;
      $display("FAIL false_start_end got b=%b v=%b f=%b exp 0 0 0",
               busy, rx_valid, framing_err);
    end
  endtask

  task automatic test_break();
    send_frame(8'h41, 104, 1'b0);
    serial_in = 1'b0;
    repeat (1000) @(negedge clk);
    checks++;
    if (framing_err !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL break_err got f=%b c=%0d b=%b exp 1 0 1",
               framing_err, fifo_count, busy);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (2000) @(negedge clk);
    checks++;
    if (framing_err !== 1'b0) begin
      errors++;
      $display("FAIL break_once got %b exp 0", framing_err);
    end
    serial_in = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL break_release got busy=%b exp 0", busy);
    end
    send_frame(8'h42, 104, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h42 || framing_err !== 1'b0) begin
      errors++;
      $display("FAIL break_next got v=%b d=%h f=%b exp 1 42 0",
               rx_valid, rx_data, framing_err);
    end
    pop1();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 104, 1'b1);
    checks++;
    if (fifo_count !== 5'd16 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_fill got c=%0d o=%b exp 16 0",
               fifo_count, overrun_err);
    end
    send_frame(8'h10, 104, 1'b1);
    checks++;
    if (fifo_count !== 5'd16 || overrun_err !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop got c=%0d o=%b exp 16 1",
               fifo_count, overrun_err);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rx_data !== 8'(i)) begin
        errors++;
        $display("FAIL ovr_drain%0d got %h exp %h", i, rx_data, 8'(i));
      end
      pop1();
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (overrun_err !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL ovr_clr got o=%b c=%0d exp 0 0",
               overrun_err, fifo_count);
    end
    for (int i = 0; i < 16; i++) send_frame(8'(i), 104, 1'b1);
    // Stop decision lands on posedge 991 (+LAT) after the start edge.
    fork
      send_frame(8'h10, 104, 1'b1);
      begin
        repeat (990 + LAT) @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    checks++;
    if (fifo_count !== 5'd16 || overrun_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_popfull got c=%0d o=%b exp 16 0",
               fifo_count, overrun_err);
    end
    for (int i = 1; i < 17; i++) begin
      checks++;
      if (rx_data !== 8'(i)) begin
        errors++;
        $display("FAIL ovr_drain2_%0d got %h exp %h", i, rx_data, 8'(i));
      end
      pop1();
    end
  endtask

  task automatic test_baud_change();
    fork
      send_frame(8'h7E, 104, 1'b1);
      begin
        repeat (300) @(negedge clk);
        baud_div = 16'd52;
      end
    join
    send_frame(8'h0D, 52, 1'b1);
    checks++;
    if (fifo_count !== 5'd2 || rx_data !== 8'h7E) begin
      errors++;
      $display("FAIL baud_first got c=%0d d=%h exp 2 7e",
               fifo_count, rx_data);
    end
    pop1();
    checks++;
    if (rx_data !== 8'h0D || framing_err !== 1'b0) begin
      errors++;
      $display("FAIL baud_second got d=%h f=%b exp 0d 0",
               rx_data, framing_err);
    end
    pop1();
    baud_div = 16'd104;
  endtask

  task automatic test_reset_mid();
    send_frame(8'h01, 104, 1'b1);
    send_frame(8'h02, 104, 1'b1);
    send_frame(8'h03, 104, 1'b1);
    serial_in = 1'b0;
    repeat (300) @(negedge clk);
    checks++;
    if (fifo_count !== 5'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got c=%0d b=%b exp 3 1", fifo_count, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rx_valid !== 1'b0 || fifo_count !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got v=%b c=%0d b=%b exp 0 0 0",
               rx_valid, fifo_count, busy);
    end
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h31, 104, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || fifo_count !== 5'd1 || rx_data !== 8'h31) begin
      errors++;
      $display("FAIL rstmid_after got v=%b c=%0d d=%h exp 1 1 31",
               rx_valid, fifo_count, rx_data);
    end
    pop1();
  endtask

  initial begin
    rst_n     = 1'b0;
    serial_in = 1'b1;
    baud_div  = 16'd104;
    rx_ready  = 1'b0;
    err_clr   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_false_start();
    test_break();
    test_overrun();
    test_baud_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
